mem_burst_responder: RTL
========================

MEM_BURST_RESPONDER -- requirements
Module: mem_burst_responder

Interface
REQ-001 SHALL have parameter LATENCY, default 4: cycles from request acceptance to first data beat (legal 1..15).
REQ-002 SHALL have parameter BURST, default 4: words per read burst (power of two, 2..8).
REQ-003 SHALL have parameter AW, default 10: log2 of word capacity of the internal array.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 rst  input  1  reset, synchronous, active-high.
REQ-006 enable  input  1  request strobe, sampled each cycle.
REQ-007 wr  input  1  1 = word write, 0 = burst read; qualifies enable.
REQ-008 addr  input  16  byte address; word index is addr[AW:1].
REQ-009 data_in  input  16  write data.
REQ-010 data_out  output  16  returned read word, registered.
REQ-011 data_valid  output  1  data_out holds a valid burst beat this cycle.
REQ-012 data_last  output  1  final beat of the burst, coincident with data_valid.
REQ-013 busy  output  1  read burst in progress; new requests ignored.

Function
REQ-014 SHALL implement states IDLE, WAIT, BEAT.
REQ-015 Read acceptance SHALL be enable & !wr & !busy in cycle T; SHALL latch block base = word index with the low log2(BURST) bits cleared, then enter WAIT.
REQ-016 busy SHALL be 1 from T+1 through the last-beat cycle inclusive, and 0 in the cycle after.
REQ-017 First beat SHALL appear at T+LATENCY; beats SHALL be consecutive at T+LATENCY .. T+LATENCY+BURST-1, with no gaps.
REQ-018 Beat k SHALL return word base+k, k = 0..BURST-1, in ascending order, independent of the requested offset within the block.
REQ-019 WAIT SHALL use a latency down-counter; BEAT SHALL use a log2(BURST)-bit beat counter. The transition BEAT->IDLE SHALL occur when the beat counter wraps from BURST-1.
REQ-020 With LATENCY=1, WAIT SHALL be skipped: the first beat is at T+1.
REQ-021 data_out SHALL be 0 whenever data_valid is 0.
REQ-022 Write acceptance SHALL be enable & wr & !busy; it SHALL store data_in at word addr[AW:1] on that edge, produce no response, and leave busy at 0.
REQ-023 A write accepted in cycle T SHALL be visible to a read accepted at T+1 or later.
REQ-024 Any request (read or write) presented while busy=1 SHALL be dropped with no side effect. There is no queuing.
REQ-025 addr[15:AW+1] and addr[0] SHALL be ignored (the address space aliases).

Reset
REQ-026 rst SHALL force state IDLE and clear both counters.
REQ-027 After rst, data_out, data_valid, data_last and busy SHALL all be 0 in the following cycle.
REQ-028 rst during WAIT or BEAT SHALL abort the burst with no further beats.
REQ-029 rst SHALL NOT clear array contents.
REQ-030 Requests presented in the same cycle as rst SHALL be ignored.

Structure
REQ-031 The state encodings and the default LATENCY/BURST values SHALL live in the shared memory-interface package also used by the cache fill controller.
REQ-032 The storage array SHALL be a single sub-module, mem_word_array: one synchronous write port and one read port addressed by the beat address.
REQ-033 The FSM and counters SHALL reside in mem_burst_responder.

Verification
REQ-034 Write words 0x1111, 0x2222, 0x3333, 0x4444 to bytes 0x0010..0x0016, then read addr 0x0014 at T -> beats 0x1111, 0x2222, 0x3333, 0x4444 at T+4..T+7; data_last only at T+7; busy low at T+8.
REQ-035 Read accepted at T; enable with wr=1 to 0x0010 at T+2 -> write dropped, and a re-read returns the original data.
REQ-036 Back-to-back: second read issued at T+8, the first cycle busy=0 -> accepted, first beat at T+12.
REQ-037 rst asserted at T+5 mid-burst -> data_valid=0 and busy=0 from T+6; a subsequent read returns the intact array data.
REQ-038 Write 0xBEEF at T, read the same block at T+1 -> 0xBEEF in the correct beat position at T+5.
REQ-039 Instance with LATENCY=1, BURST=8 -> read at T gives beats T+1..T+8; busy falls at T+9.

Source files
------------

// File: rtl/mem_burst_responder_pkg.sv
// Shared memory-interface definitions: burst FSM state encoding and default
// burst timing, common to the burst responder and the cache fill controller.
package mem_burst_responder_pkg;

    localparam int unsigned DEFAULT_LATENCY = 32'd4;
    localparam int unsigned DEFAULT_BURST   = 32'd4;
    localparam int unsigned DATA_W          = 32'd16;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_BEAT = 2'd2
    } burst_state_e;

endpackage

// File: rtl/mem_word_array.sv
// Word storage: one synchronous write port and one combinational read port.
// Contents are deliberately not reset.
module mem_word_array
    import mem_burst_responder_pkg::*;
#(
    parameter int unsigned AW = 32'd10
) (
    input  logic              clk,
    input  logic              wr_en,
    input  logic [AW-1:0]     wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic [AW-1:0]     rd_addr,
    output logic [DATA_W-1:0] rd_data
);

    logic [DATA_W-1:0] mem_q [0:(1 << AW) - 1];

    // Write port: store one word on an accepted write.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem_q[rd_addr];

endmodule

// File: rtl/mem_burst_responder.sv
// Burst read / single-word write responder. A read returns BURST consecutive
// words of the aligned block, the first one LATENCY cycles after acceptance.
module mem_burst_responder
    import mem_burst_responder_pkg::*;
#(
    parameter int unsigned LATENCY = DEFAULT_LATENCY,
    parameter int unsigned BURST   = DEFAULT_BURST,
    parameter int unsigned AW      = 32'd10
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        enable,
    input  logic        wr,
    input  logic [15:0] addr,
    input  logic [15:0] data_in,
    output logic [15:0] data_out,
    output logic        data_valid,
    output logic        data_last,
    output logic        busy
);

    localparam int unsigned    BW        = $clog2(BURST);
    localparam logic [3:0]     LAT_LOAD  = (LATENCY > 32'd1) ? 4'(LATENCY - 32'd2) : 4'd0;
    localparam logic [BW-1:0]  LAST_BEAT = BW'(BURST - 32'd1);

    burst_state_e   state_q, state_d;
    logic [3:0]     lat_cnt_q, lat_cnt_d;
    logic [BW-1:0]  beat_cnt_q, beat_cnt_d;
    logic [AW-1:0]  base_q, base_d;
    logic [15:0]    data_out_q, data_out_d;
    logic           data_valid_q, data_valid_d;
    logic           data_last_q, data_last_d;
    logic           busy_q, busy_d;

    logic [AW-1:0]  word_idx;
    logic [AW-1:0]  req_base;
    logic [AW-1:0]  rd_addr;
    logic [15:0]    rd_data;
    logic           rd_accept;
    logic           wr_accept;
    logic           issue;
    logic [BW-1:0]  issue_beat;
    logic           unused_addr_bits;

    assign word_idx         = addr[AW:1];
    assign req_base         = {word_idx[AW-1:BW], {BW{1'b0}}};
    assign rd_accept        = enable & ~wr & ~busy_q & ~rst;
    assign wr_accept        = enable &  wr & ~busy_q & ~rst;
    assign unused_addr_bits = ^{addr[15:AW+1], addr[0]};

    // Beat address: the request itself when LATENCY=1 issues from IDLE,
    // otherwise the latched block base plus the running beat offset.
    always_comb begin
        rd_addr = base_q;
        if (state_q == ST_BEAT) begin
            rd_addr = base_q | AW'(beat_cnt_q);
        end else if (state_q == ST_IDLE) begin
            rd_addr = req_base;
        end else begin
            rd_addr = base_q;
        end
    end

    mem_word_array #(.AW(AW)) u_array (
        .clk     (clk),
        .wr_en   (wr_accept),
        .wr_addr (word_idx),
        .wr_data (data_in),
        .rd_addr (rd_addr),
        .rd_data (rd_data)
    );

    // Next state; a beat "issued" here becomes visible on the outputs next cycle.
    always_comb begin
        state_d    = state_q;
        lat_cnt_d  = lat_cnt_q;
        beat_cnt_d = beat_cnt_q;
        base_d     = base_q;
        busy_d     = 1'b0;
        issue      = 1'b0;
        issue_beat = '0;
        case (state_q)
            ST_IDLE: begin
                if (rd_accept) begin
                    base_d = req_base;
                    busy_d = 1'b1;
                    if (LATENCY == 32'd1) begin
                        issue      = 1'b1;
                        beat_cnt_d = BW'(1);
                        state_d    = ST_BEAT;
                    end else begin
                        lat_cnt_d = LAT_LOAD;
                        state_d   = ST_WAIT;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_WAIT: begin
                busy_d = 1'b1;
                if (lat_cnt_q == 4'd0) begin
                    issue      = 1'b1;
                    beat_cnt_d = BW'(1);
                    state_d    = ST_BEAT;
                end else begin
                    lat_cnt_d = lat_cnt_q - 4'd1;
                end
            end
            ST_BEAT: begin
                busy_d     = 1'b1;
                issue      = 1'b1;
                issue_beat = beat_cnt_q;
                beat_cnt_d = beat_cnt_q + BW'(1);
                if (beat_cnt_q == LAST_BEAT) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_BEAT;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        data_valid_d = issue;
        data_last_d  = issue & (issue_beat == LAST_BEAT);
        data_out_d   = issue ? rd_data : 16'd0;
    end

    // State, counters and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            lat_cnt_q    <= 4'd0;
            beat_cnt_q   <= '0;
            base_q       <= '0;
            data_out_q   <= 16'd0;
            data_valid_q <= 1'b0;
            data_last_q  <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            lat_cnt_q    <= lat_cnt_d;
            beat_cnt_q   <= beat_cnt_d;
            base_q       <= base_d;
            data_out_q   <= data_out_d;
            data_valid_q <= data_valid_d;
            data_last_q  <= data_last_d;
            busy_q       <= busy_d;
        end
    end

    assign data_out   = data_out_q;
    assign data_valid = data_valid_q;
    assign data_last  = data_last_q;
    assign busy       = busy_q;

endmodule
